// File: rtl/fma_tile_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fma_tile_sequencer_if                                                      |
// | Job, FMA and result signals between the tile sequencer and its neighbours. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface fma_tile_sequencer_if #(
  parameter int ACCUMULATOR_WIDTH = 24,
  parameter int ADDR_W            = 8,
  parameter int TILE_W            = 8
);
  localparam int MAT_W = 64 * ACCUMULATOR_WIDTH;

  logic              job_valid;
  logic              job_ready;
  logic [ADDR_W-1:0] job_b_base;
  logic [TILE_W-1:0] job_num_tiles;
  logic              job_clear;
  logic [MAT_W-1:0]  job_c_init;
  logic [TILE_W-1:0] a_tile_idx;
  logic              fma_start;
  logic              fma_done;
  logic [7:0]        fma_addr_b;
  logic [ADDR_W-1:0] mem_addr_b;
  logic [MAT_W-1:0]  fma_mat_c;
  logic [MAT_W-1:0]  fma_mat_out;
  logic              res_valid;
  logic              res_ready;
  logic [MAT_W-1:0]  res_data;
  logic              res_err;
  logic              busy;

  // slave = the sequencer itself; master = front end, FMA and result consumer
  modport slave (
    input  job_valid, job_b_base, job_num_tiles, job_clear, job_c_init,
    input  fma_done, fma_addr_b, fma_mat_out, res_ready,
    output job_ready, a_tile_idx, fma_start, mem_addr_b, fma_mat_c,
    output res_valid, res_data, res_err, busy
  );

  modport master (
    output job_valid, job_b_base, job_num_tiles, job_clear, job_c_init,
    output fma_done, fma_addr_b, fma_mat_out, res_ready,
    input  job_ready, a_tile_idx, fma_start, mem_addr_b, fma_mat_c,
    input  res_valid, res_data, res_err, busy
  );
endinterface
`default_nettype wire

// File: rtl/fma_tile_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fma_tile_sequencer                                                         |
// | Drives one matrix_fma_8x8 over N K-tiles: C = C0 + sum(A_t * B_t).         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module fma_tile_sequencer #(
  parameter int ACCUMULATOR_WIDTH = 24,
  parameter int ADDR_W            = 8,
  parameter int TILE_W            = 8,
  parameter int TIMEOUT           = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  fma_tile_sequencer_if.slave  sif
);
  localparam int MAT_W = 64 * ACCUMULATOR_WIDTH;
  localparam int WD_W  = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ISSUE  = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_RESULT = 2'd3;

  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  logic [1:0]        state_q,  state_d;
  logic [ADDR_W-1:0] base_q,   base_d;
  logic [TILE_W-1:0] ntiles_q, ntiles_d;
  logic [TILE_W-1:0] tile_q,   tile_d;
  logic [MAT_W-1:0]  acc_q,    acc_d;
  logic [WD_W-1:0]   wd_q,     wd_d;
  logic              err_q,    err_d;

  logic              w_last_tile;
  logic [ADDR_W-1:0] w_mem_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      base_q   <= '0;
      ntiles_q <= '0;
      tile_q   <= '0;
      acc_q    <= '0;
      wd_q     <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      ntiles_q <= ntiles_d;
      tile_q   <= tile_d;
      acc_q    <= acc_d;
      wd_q     <= wd_d;
      err_q    <= err_d;
    end
  end

  assign w_last_tile = (tile_q == ntiles_q - TILE_W'(1));

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    ntiles_d = ntiles_q;
    tile_d   = tile_q;
    acc_d    = acc_q;
    wd_d     = wd_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (sif.job_valid) begin
          base_d   = sif.job_b_base;
          ntiles_d = sif.job_num_tiles;
          tile_d   = '0;
          acc_d    = sif.job_clear ? '0 : sif.job_c_init;
          err_d    = 1'b0;
          state_d  = (sif.job_num_tiles == '0) ? S_RESULT : S_ISSUE;
        end
      end
      S_ISSUE: begin
        wd_d    = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        wd_d = wd_q + WD_W'(1);
        // A completion arriving on the expiry cycle still counts as success.
        if (sif.fma_done) begin
          acc_d = sif.fma_mat_out;
          if (w_last_tile) begin
            state_d = S_RESULT;
          end else begin
            tile_d  = tile_q + TILE_W'(1);
            state_d = S_ISSUE;
          end
        end else if (wd_q == WD_LAST) begin
          err_d   = 1'b1;
          state_d = S_RESULT;
        end
      end
      S_RESULT: begin
        if (sif.res_ready) begin
          err_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // B row address: per-tile stride of 8 rows, wrapping modulo the memory size.
  assign w_mem_addr = base_q + ADDR_W'({tile_q, 3'b000}) + ADDR_W'(sif.fma_addr_b);

  always_comb begin
    sif.job_ready  = (state_q == S_IDLE);
    sif.fma_start  = (state_q == S_ISSUE);
    sif.res_valid  = (state_q == S_RESULT);
    sif.busy       = (state_q != S_IDLE);
    sif.res_err    = err_q & (state_q == S_RESULT);
    sif.res_data   = acc_q;
    sif.fma_mat_c  = acc_q;
    sif.a_tile_idx = tile_q;
    sif.mem_addr_b = w_mem_addr;
  end
endmodule
`default_nettype wire

// File: tb/tb_fma_tile_sequencer.sv
`default_nettype none
// Bench for fma_tile_sequencer: a behavioural FMA stand-in plus a tile-sum
// reference model built directly from C = C0 + sum(A_t * B_t).
module tb_fma_tile_sequencer;
  localparam int AW      = 24;
  localparam int ADDR_W  = 8;
  localparam int TILE_W  = 8;
  localparam int TIMEOUT = 64;
  localparam int MAT_W   = 64 * AW;
  localparam int PERIOD  = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #(PERIOD / 2) clk = ~clk;

  fma_tile_sequencer_if #(.ACCUMULATOR_WIDTH(AW), .ADDR_W(ADDR_W), .TILE_W(TILE_W)) sif ();

  fma_tile_sequencer #(
    .ACCUMULATOR_WIDTH(AW), .ADDR_W(ADDR_W), .TILE_W(TILE_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sif(sif.slave)
  );

  int n_checks = 0;
  int n_err    = 0;

  // B memory: one 8-byte row per address; A tiles: byte (i*8+k) = A[i][k]
  logic [63:0]  bmem [256];
  logic [511:0] amem [16];

  // FMA stand-in: reads B rows 0..7, samples mat_c/A, completes m_lat cycles into WAIT
  int               m_lat  = 11;
  int               m_cnt  = 0;
  bit               m_pend = 1'b0;
  logic [511:0]     m_a    = '0;
  logic [511:0]     m_b    = '0;
  logic [MAT_W-1:0] m_c    = '0;
  logic [MAT_W-1:0] m_out  = '0;
  time              start_t[$];
  int               mc_q[$];
  int               addr_q[$];
  logic [MAT_W-1:0] last_res;

  function automatic logic [MAT_W-1:0] fma_calc(input logic [MAT_W-1:0] c,
                                                input logic [511:0] a,
                                                input logic [511:0] b);
    logic [MAT_W-1:0] r;
    logic [AW-1:0]    s;
    r = '0;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) begin
        s = c[(i*8+j)*AW +: AW];
        for (int k = 0; k < 8; k++)
          s = s + AW'(a[(i*8+k)*8 +: 8]) * AW'(b[k*64 + j*8 +: 8]);
        r[(i*8+j)*AW +: AW] = s;
      end
    return r;
  endfunction

  always @(posedge clk) begin
    if (sif.fma_start) begin
      start_t.push_back($time);
      m_pend <= 1'b1;
      m_cnt  <= 0;
    end else if (m_pend) begin
      if (m_cnt < 8) begin
        m_b[m_cnt*64 +: 64] <= bmem[sif.mem_addr_b];
        addr_q.push_back(int'(sif.mem_addr_b));
      end
      if (m_cnt == 2) begin
        m_c <= sif.fma_mat_c;
        m_a <= amem[sif.a_tile_idx[3:0]];
        mc_q.push_back(int'(sif.fma_mat_c[AW-1:0]));
      end
      if (m_cnt == 8) m_out <= fma_calc(m_c, m_a, m_b);
      if (m_cnt == m_lat) m_pend <= 1'b0;
      m_cnt <= m_cnt + 1;
    end
  end

  assign sif.fma_done    = m_pend && (m_cnt == m_lat);
  assign sif.fma_addr_b  = (m_pend && m_cnt < 8) ? 8'(m_cnt) : 8'd0;
  assign sif.fma_mat_out = m_out;

  // Reference: element-wise sum over tiles, B row k of tile t at (base + 8t + k) mod 256
  function automatic logic [MAT_W-1:0] ref_job(input int base, input int n, input bit clear,
                                               input logic [MAT_W-1:0] c0);
    logic [MAT_W-1:0] r;
    logic [511:0]     at;
    logic [63:0]      brow;
    longint           sum;
    r = '0;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) begin
        sum = clear ? 0 : longint'(c0[(i*8+j)*AW +: AW]);
        for (int t = 0; t < n; t++) begin
          at = amem[t];
          for (int k = 0; k < 8; k++) begin
            brow = bmem[(base + 8*t + k) % 256];
            sum += longint'(at[(i*8+k)*8 +: 8]) * longint'(brow[j*8 +: 8]);
          end
        end
        r[(i*8+j)*AW +: AW] = sum[AW-1:0];
      end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_mat(input string tag, input logic [MAT_W-1:0] obs, input logic [MAT_W-1:0] exp);
    int idx;
    idx = 0;
    for (int e = 63; e >= 0; e--)
      if (obs[e*AW +: AW] !== exp[e*AW +: AW]) idx = e;
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s elem=%0d observed=%0h expected=%0h", tag, idx,
             obs[idx*AW +: AW], exp[idx*AW +: AW]);
    end
  endtask

  function automatic logic [MAT_W-1:0] fill(input int v);
    logic [MAT_W-1:0] r;
    for (int e = 0; e < 64; e++) r[e*AW +: AW] = AW'(v);
    return r;
  endfunction

  function automatic logic [MAT_W-1:0] rand_mat();
    logic [MAT_W-1:0] r;
    for (int e = 0; e < 64; e++) r[e*AW +: AW] = AW'($urandom);
    return r;
  endfunction

  task automatic rand_a();
    for (int t = 0; t < 16; t++)
      for (int b = 0; b < 64; b++) amem[t][b*8 +: 8] = 8'($urandom_range(0, 15));
  endtask

  // One job: offer, measure latency from the accept cycle, optional backpressure, handshake.
  task automatic run_job(input int base, input int n, input bit clear,
                         input logic [MAT_W-1:0] c0, input int hold, input string tag);
    logic [MAT_W-1:0] exp_d;
    logic [MAT_W-1:0] r0;
    logic             e0;
    int  lat, exp_lat, exp_starts, s0;
    bit  exp_err, stable, spacing_ok;
    exp_err    = (n > 0) && (m_lat >= TIMEOUT);
    exp_d      = exp_err ? ref_job(base, 0, clear, c0) : ref_job(base, n, clear, c0);
    exp_lat    = (n == 0) ? 1 : (exp_err ? 2 + TIMEOUT : 1 + n * (m_lat + 2));
    exp_starts = (n == 0) ? 0 : (exp_err ? 1 : n);
    @(negedge clk);
    chk({tag, "_ready"}, 64'(sif.job_ready), 64'd1);
    s0 = start_t.size();
    sif.job_valid     = 1'b1;
    sif.job_b_base    = ADDR_W'(base);
    sif.job_num_tiles = TILE_W'(n);
    sif.job_clear     = clear;
    sif.job_c_init    = c0;
    @(posedge clk);
    @(negedge clk);
    sif.job_valid = 1'b0;
    lat = 1;
    while (!sif.res_valid && lat < 500) begin
      @(negedge clk);
      lat++;
    end
    last_res = sif.res_data;
    chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    chk_mat({tag, "_data"}, sif.res_data, exp_d);
    chk({tag, "_err"}, 64'(sif.res_err), 64'(exp_err));
    chk({tag, "_starts"}, 64'(start_t.size() - s0), 64'(exp_starts));
    if (exp_starts > 1) begin
      spacing_ok = 1'b1;
      for (int i = 1; i < exp_starts; i++)
        if (start_t[s0+i] - start_t[s0+i-1] != time'((m_lat + 2) * PERIOD)) spacing_ok = 1'b0;
      chk({tag, "_spacing"}, 64'(spacing_ok), 64'd1);
    end
    if (hold > 0) begin
      r0 = sif.res_data;
      e0 = sif.res_err;
      stable = 1'b1;
      sif.job_valid  = 1'b1;
      sif.job_b_base = ADDR_W'(base + 1);
      sif.job_c_init = ~c0;
      repeat (hold) begin
        @(negedge clk);
        if (sif.res_data !== r0 || sif.res_err !== e0 || sif.job_ready !== 1'b0 ||
            sif.res_valid !== 1'b1) stable = 1'b0;
      end
      sif.job_valid = 1'b0;
      chk({tag, "_hold_stable"}, 64'(stable), 64'd1);
    end
    sif.res_ready = 1'b1;
    @(negedge clk);
    sif.res_ready = 1'b0;
    chk({tag, "_idle_after"}, {62'd0, sif.job_ready, sif.busy}, 64'b10);
  endtask

  initial begin
    #(PERIOD * 100000);
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench did not finish");
  end

  initial begin
    logic [MAT_W-1:0] c0;
    int s0, k;
    bit ok;
    sif.job_valid = 1'b0; sif.job_b_base = '0; sif.job_num_tiles = '0;
    sif.job_clear = 1'b0; sif.job_c_init = '0; sif.res_ready = 1'b0;
    for (int a = 0; a < 256; a++)
      for (int j = 0; j < 8; j++) bmem[a][j*8 +: 8] = 8'($urandom_range(0, 15));
    rand_a();

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_outputs", {58'd0, sif.job_ready, sif.fma_start, sif.res_valid, sif.res_err,
                        sif.busy, 1'b0}, 64'b100000);
    chk("rst_tile_idx", 64'(sif.a_tile_idx), 64'd0);
    chk_mat("rst_acc", sif.fma_mat_c, '0);
    rst = 1'b0;

    // Identity A, B of all 5s at 0x10
    amem[0] = '0;
    for (int i = 0; i < 8; i++) amem[0][(i*8+i)*8 +: 8] = 8'd1;
    for (int a = 16; a < 24; a++) bmem[a] = {8{8'd5}};
    run_job(16, 1, 1'b1, rand_mat(), 0, "ident");
    chk_mat("ident_all5", last_res, fill(5));

    // A all 2s, B all 3s, three tiles, C0 all 10
    for (int t = 0; t < 3; t++) amem[t] = {64{8'd2}};
    for (int a = 0; a < 24; a++) bmem[a] = {8{8'd3}};
    s0 = mc_q.size();
    run_job(0, 3, 1'b0, fill(10), 0, "acc3");
    chk("acc3_matc0", 64'(mc_q[s0]),   64'd10);
    chk("acc3_matc1", 64'(mc_q[s0+1]), 64'd58);
    chk("acc3_matc2", 64'(mc_q[s0+2]), 64'd106);
    chk_mat("acc3_all154", last_res, fill(154));

    // Zero tiles
    run_job(0, 0, 1'b0, fill(7), 0, "zero");
    chk_mat("zero_all7", last_res, fill(7));

    // FMA never completes, then completion exactly on the expiry cycle, then normal
    rand_a();
    m_lat = 1000;
    c0 = rand_mat();
    run_job(int'($urandom_range(0, 255)), 1, 1'b0, c0, 0, "tmo");
    chk_mat("tmo_c0", last_res, c0);
    m_lat = TIMEOUT - 1;
    run_job(int'($urandom_range(0, 255)), 2, 1'b0, rand_mat(), 0, "edge");
    m_lat = 11;
    run_job(int'($urandom_range(0, 255)), 1, 1'b1, rand_mat(), 0, "after_tmo");

    // Result backpressure with a competing job offered
    run_job(int'($urandom_range(0, 255)), 2, 1'b0, rand_mat(), 20, "bp");

    // Reset in the WAIT of tile 1 of 4
    @(negedge clk);
    s0 = start_t.size();
    sif.job_valid = 1'b1; sif.job_b_base = 8'h40; sif.job_num_tiles = 8'd4;
    sif.job_clear = 1'b1; sif.job_c_init = rand_mat();
    @(posedge clk);
    @(negedge clk);
    sif.job_valid = 1'b0;
    k = 0;
    while (start_t.size() < s0 + 2 && k < 200) begin
      @(negedge clk);
      k++;
    end
    repeat (4) @(negedge clk);
    chk("mid_tile_idx", 64'(sif.a_tile_idx), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_outputs", {58'd0, sif.job_ready, sif.fma_start, sif.res_valid, sif.res_err,
                           sif.busy, 1'b0}, 64'b100000);
    chk("midrst_tile_idx", 64'(sif.a_tile_idx), 64'd0);
    chk_mat("midrst_acc", sif.fma_mat_c, '0);
    ok = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (sif.res_valid !== 1'b0 || sif.busy !== 1'b0 || sif.fma_start !== 1'b0) ok = 1'b0;
    end
    chk("late_done_ignored", 64'(ok), 64'd1);

    // Address wrap at the top of B memory
    s0 = addr_q.size();
    run_job(252, 1, 1'b1, rand_mat(), 0, "wrap");
    ok = (addr_q.size() >= s0 + 8);
    if (ok)
      for (int r = 0; r < 8; r++)
        if (addr_q[s0+r] != (252 + r) % 256) ok = 1'b0;
    chk("wrap_addrs", 64'(ok), 64'd1);

    // Randomized jobs
    rand_a();
    for (int j = 0; j < 6; j++)
      run_job(int'($urandom_range(0, 255)), int'($urandom_range(0, 4)), 1'($urandom),
              rand_mat(), int'($urandom_range(0, 3)), $sformatf("rnd%0d", j));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
